unique0_sel_checker: RTL and testbench
======================================

Name: unique0_sel_checker

Overview:
Registered, parametrised N-way condition selector with unique0/unique semantic checking in hardware. Each accepted input vector of N condition bits is resolved to the first true condition, or to the fallback "else" when none is true. Zero, one or multiple true conditions are flagged according to MODE. Sits between condition-generating logic and downstream consumers, with valid/ready handshake, a saturating violation counter and a sticky error flag.

Parameters:
N, 4, number of condition lines (2..32)
MODE, 1, 0 = priority (no check), 1 = unique0 (>1 true is violation), 2 = unique (count != 1 is violation)
CNT_W, 8, width of violation counter
IDX_W, $clog2(N), width of selected index (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept input
cond  in  N  condition bits, bit 0 highest priority
out_valid  out  1  result register holds valid result
out_ready  in  1  downstream accepts result
out_idx  out  IDX_W  index of lowest set cond bit; 0 when none set
out_hit  out  1  at least one condition true; 0 = fallback/else taken
out_multi  out  1  more than one condition true
out_viol  out  1  result violates MODE rule
viol_cnt  out  CNT_W  saturating count of accepted violating vectors
err_sticky  out  1  set by any violation, held until cleared
clr_err  in  1  clears err_sticky and viol_cnt

Behaviour:
- Reset (rst=1 at clk edge): out_valid, out_idx, out_hit, out_multi, out_viol, viol_cnt, err_sticky all 0. Reset overrides every other event, including mid-transfer; a held result is discarded.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept when in_valid && in_ready. Result is registered with 1-cycle latency: out_valid=1 on the following cycle.
- Full throughput: back-to-back accepts are allowed while out_ready=1.
- If out_valid && !out_ready, all out_* fields hold stable and in_ready=0.
- out_valid falls after an out_ready handshake with no new accept in the same cycle.
- Resolution:
  - out_idx = lowest index i with cond[i]=1.
  - out_hit = |cond.
  - out_multi = popcount(cond) > 1.
  - When multiple bits are set, out_idx still reports the priority (lowest) winner.
- Violation:
  - MODE0: out_viol always 0.
  - MODE1: out_viol = out_multi.
  - MODE2: out_viol = (popcount != 1), so cond=0 is also a violation.
- viol_cnt: increments by 1 on each accepted violating vector and saturates at 2^CNT_W-1 (no wrap).
- err_sticky: set on each accepted violating vector.
- clr_err (registered effect):
  - Zeroes viol_cnt and err_sticky.
  - If clr_err and a violating accept occur in the same cycle, set/increment wins: err_sticky=1, viol_cnt=1.
- cond is sampled only on accept. Changes while not accepted have no effect.
- Assertions (simulation only):
  - IDX_W width check.
  - MODE in {0,1,2}.
  - Out fields stable while out_valid && !out_ready.

Test Plan:
1. MODE=1, N=4. After reset all outputs are 0 and in_ready=1. Send cond=4'b0000 -> next cycle out_valid=1, out_hit=0, out_idx=0, out_viol=0, viol_cnt=0 (else-branch case).
2. MODE=1. Send cond=4'b0100 -> out_idx=2, out_hit=1, out_multi=0, out_viol=0. Then send cond=4'b1010 -> out_idx=1, out_multi=1, out_viol=1, viol_cnt=1, err_sticky=1.
3. MODE=2. Send cond=0, then 4'b1000, then 4'b0011 -> out_viol = 1, 0, 1; viol_cnt=2. MODE=0 with the same stimulus -> out_viol=0 throughout and viol_cnt=0.
4. Backpressure: hold out_ready=0 after one accept -> in_ready=0 and out fields stable for 5 cycles. Raise out_ready with in_valid=1 -> accept in the same cycle, next result appears 1 cycle later with no bubble.
5. CNT_W=2, MODE=1. Send 5 vectors with cond=4'b1111 -> viol_cnt sequence 1, 2, 3, 3, 3. Then pulse clr_err alone -> viol_cnt=0, err_sticky=0. Pulse clr_err together with a violating accept -> viol_cnt=1, err_sticky=1.
6. Assert rst while out_valid=1 and viol_cnt=3 -> next cycle all outputs are 0 and in_ready=1.

Source files
------------

// File: rtl/unique0_sel_checker.sv
// unique0_sel_checker: registered N-way priority selector that also checks
// unique0/unique semantics of the condition vector. A violation counter
// saturates at its maximum and a sticky error flag records any violation.
//
// Handshake: a vector is accepted on a rising clock edge when in_valid and
// in_ready are both high. in_ready = !out_valid || out_ready and does not
// look at in_valid. A result is transferred downstream when out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// every out_* field holds its value.
module unique0_sel_checker #(
   parameter  int N     = 4,
   parameter  int MODE  = 1,
   parameter  int CNT_W = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_hit,
   output logic             out_multi,
   output logic             out_viol,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             err_sticky,
   input  logic             clr_err
);

   // Wide enough to hold a popcount of N bits.
   localparam int POP_W = $clog2(N + 1);

   logic [IDX_W-1:0] sel_idx;
   logic [POP_W-1:0] pop;
   logic             sel_found;
   logic             sel_hit;
   logic             sel_multi;
   logic             sel_viol;
   logic             accept;

   logic             out_valid_q,  out_valid_d;
   logic [IDX_W-1:0] out_idx_q,    out_idx_d;
   logic             out_hit_q,    out_hit_d;
   logic             out_multi_q,  out_multi_d;
   logic             out_viol_q,   out_viol_d;
   logic [CNT_W-1:0] viol_cnt_q,   viol_cnt_d;
   logic             err_sticky_q, err_sticky_d;

   // Resolve the incoming vector: lowest set bit wins, count the set bits.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      pop       = '0;
      for (int i = 0; i < N; i++) begin
         if (cond[i] && !sel_found) begin
            sel_idx   = IDX_W'(i);
            sel_found = 1'b1;
         end
         pop = pop + POP_W'(cond[i]);
      end
   end

   // Classify the vector against the selected checking mode.
   always_comb begin
      sel_hit   = |cond;
      sel_multi = (pop > POP_W'(1));
      sel_viol  = 1'b0;
      if (MODE == 1) begin
         sel_viol = sel_multi;
      end else if (MODE == 2) begin
         sel_viol = (pop != POP_W'(1));
      end
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Next-state for the result register and the error bookkeeping.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_idx_d    = out_idx_q;
      out_hit_d    = out_hit_q;
      out_multi_d  = out_multi_q;
      out_viol_d   = out_viol_q;
      viol_cnt_d   = viol_cnt_q;
      err_sticky_d = err_sticky_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_idx_d   = sel_idx;
         out_hit_d   = sel_hit;
         out_multi_d = sel_multi;
         out_viol_d  = sel_viol;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // Clear first, so a violation in the same cycle still registers.
      if (clr_err) begin
         viol_cnt_d   = '0;
         err_sticky_d = 1'b0;
      end
      if (accept && sel_viol) begin
         err_sticky_d = 1'b1;
         if (viol_cnt_d != {CNT_W{1'b1}}) begin
            viol_cnt_d = viol_cnt_d + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         out_hit_q    <= 1'b0;
         out_multi_q  <= 1'b0;
         out_viol_q   <= 1'b0;
         viol_cnt_q   <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_idx_q    <= out_idx_d;
         out_hit_q    <= out_hit_d;
         out_multi_q  <= out_multi_d;
         out_viol_q   <= out_viol_d;
         viol_cnt_q   <= viol_cnt_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_idx    = out_idx_q;
   assign out_hit    = out_hit_q;
   assign out_multi  = out_multi_q;
   assign out_viol   = out_viol_q;
   assign viol_cnt   = viol_cnt_q;
   assign err_sticky = err_sticky_q;

   a_idx_w: assert property (@(posedge clk)
      (IDX_W == $clog2(N)) && (N >= 2) && (N <= 32));

   a_mode: assert property (@(posedge clk) MODE inside {0, 1, 2});

   a_hold: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !out_ready) |=>
         (out_valid_q && $stable(out_idx_q) && $stable(out_hit_q) &&
          $stable(out_multi_q) && $stable(out_viol_q)));

endmodule

// File: tb/tb_unique0_sel_checker.sv
// tb_unique0_sel_checker: four instances share one stimulus stream:
//   0: MODE=1, CNT_W=8   1: MODE=2, CNT_W=8
//   2: MODE=0, CNT_W=8   3: MODE=1, CNT_W=2
module tb_unique0_sel_checker;

   localparam int NI = 4;
   localparam int MODES [NI] = '{1, 2, 0, 1};
   localparam int CMAX  [NI] = '{255, 255, 255, 3};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       clr_err = 1'b0;
   logic [3:0] cond = 4'b0000;

   logic       o_ready [NI];
   logic       o_valid [NI];
   logic [1:0] o_idx   [NI];
   logic       o_hit   [NI];
   logic       o_multi [NI];
   logic       o_viol  [NI];
   logic [7:0] o_cnt   [NI];
   logic       o_err   [NI];
   logic [7:0] cnt0, cnt1, cnt2;
   logic [1:0] cnt3;

   assign o_cnt[0] = cnt0;
   assign o_cnt[1] = cnt1;
   assign o_cnt[2] = cnt2;
   assign o_cnt[3] = {6'b0, cnt3};

   // Reference model state.
   bit m_valid;
   int m_idx;
   bit m_hit;
   bit m_multi;
   bit m_viol [NI];
   int m_cnt  [NI];
   bit m_err  [NI];

   int n_checks = 0;
   int n_errors = 0;

   // Clock / reset
   always #5 clk = ~clk;

   unique0_sel_checker #(.N(4), .MODE(1), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[0]),
      .cond(cond), .out_valid(o_valid[0]), .out_ready(out_ready),
      .out_idx(o_idx[0]), .out_hit(o_hit[0]), .out_multi(o_multi[0]),
      .out_viol(o_viol[0]), .viol_cnt(cnt0), .err_sticky(o_err[0]),
      .clr_err(clr_err));

   unique0_sel_checker #(.N(4), .MODE(2), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[1]),
      .cond(cond), .out_valid(o_valid[1]), .out_ready(out_ready),
      .out_idx(o_idx[1]), .out_hit(o_hit[1]), .out_multi(o_multi[1]),
      .out_viol(o_viol[1]), .viol_cnt(cnt1), .err_sticky(o_err[1]),
      .clr_err(clr_err));

   unique0_sel_checker #(.N(4), .MODE(0), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[2]),
      .cond(cond), .out_valid(o_valid[2]), .out_ready(out_ready),
      .out_idx(o_idx[2]), .out_hit(o_hit[2]), .out_multi(o_multi[2]),
      .out_viol(o_viol[2]), .viol_cnt(cnt2), .err_sticky(o_err[2]),
      .clr_err(clr_err));

   unique0_sel_checker #(.N(4), .MODE(1), .CNT_W(2)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[3]),
      .cond(cond), .out_valid(o_valid[3]), .out_ready(out_ready),
      .out_idx(o_idx[3]), .out_hit(o_hit[3]), .out_multi(o_multi[3]),
      .out_viol(o_viol[3]), .viol_cnt(cnt3), .err_sticky(o_err[3]),
      .clr_err(clr_err));

   // Driver: advance the model with the current inputs, then one clock edge.
   task automatic tick();
      bit acc;
      int pc;
      int lo;
      bit v;
      if (rst) begin
         m_valid = 0; m_idx = 0; m_hit = 0; m_multi = 0;
         for (int k = 0; k < NI; k++) begin
            m_viol[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
         end
      end else begin
         acc = in_valid && (!m_valid || out_ready);
         pc  = $countones(cond);
         lo  = 0;
         for (int i = 3; i >= 0; i--) if (cond[i]) lo = i;
         for (int k = 0; k < NI; k++) begin
            if (clr_err) begin
               m_cnt[k] = 0;
               m_err[k] = 0;
            end
            if (acc) begin
               v = (MODES[k] == 1) ? (pc > 1) : (MODES[k] == 2) ? (pc != 1) : 1'b0;
               m_viol[k] = v;
               if (v) begin
                  m_err[k] = 1;
                  if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
               end
            end
         end
         if (acc) begin
            m_valid = 1; m_idx = lo; m_hit = (pc > 0); m_multi = (pc > 1);
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] c);
      in_valid = 1'b1;
      cond = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (o_valid[k] !== 0 || o_idx[k] !== 0 || o_hit[k] !== 0 || o_multi[k] !== 0 ||
             o_viol[k] !== 0 || o_cnt[k] !== 0 || o_err[k] !== 0 || o_ready[k] !== 1) begin
            n_errors++;
            $display("FAIL reset inst%0d: got v=%b i=%0d h=%b m=%b x=%b c=%0d e=%b r=%b want all 0, in_ready=1",
               k, o_valid[k], o_idx[k], o_hit[k], o_multi[k], o_viol[k], o_cnt[k], o_err[k], o_ready[k]);
         end
      end
   endtask

   task automatic test_else();
      send(4'b0000);
      n_checks++;
      if (o_valid[0] !== 1 || o_hit[0] !== 0 || o_idx[0] !== 0 || o_viol[0] !== 0 || o_cnt[0] !== 0) begin
         n_errors++;
         $display("FAIL else_case: got v=%b h=%b i=%0d x=%b c=%0d want v=1 h=0 i=0 x=0 c=0",
            o_valid[0], o_hit[0], o_idx[0], o_viol[0], o_cnt[0]);
      end
   endtask

   task automatic test_resolve();
      send(4'b0100);
      n_checks++;
      if (o_idx[0] !== 2 || o_hit[0] !== 1 || o_multi[0] !== 0 || o_viol[0] !== 0) begin
         n_errors++;
         $display("FAIL resolve_single: got i=%0d h=%b m=%b x=%b want i=2 h=1 m=0 x=0",
            o_idx[0], o_hit[0], o_multi[0], o_viol[0]);
      end
      send(4'b1010);
      n_checks++;
      if (o_idx[0] !== 1 || o_multi[0] !== 1 || o_viol[0] !== 1 || o_cnt[0] !== 1 || o_err[0] !== 1) begin
         n_errors++;
         $display("FAIL resolve_multi: got i=%0d m=%b x=%b c=%0d e=%b want i=1 m=1 x=1 c=1 e=1",
            o_idx[0], o_multi[0], o_viol[0], o_cnt[0], o_err[0]);
      end
   endtask

   task automatic test_modes();
      logic [3:0] vecs [3];
      bit         exp2 [3];
      vecs = '{4'b0000, 4'b1000, 4'b0011};
      exp2 = '{1'b1, 1'b0, 1'b1};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         send(vecs[j]);
         n_checks++;
         if (o_viol[1] !== exp2[j] || o_viol[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL modes_viol vec%0d: got mode2=%b mode0=%b want mode2=%b mode0=0",
               j, o_viol[1], o_viol[2], exp2[j]);
         end
      end
      n_checks++;
      if (o_cnt[1] !== 2 || o_err[1] !== 1 || o_cnt[2] !== 0 || o_err[2] !== 0) begin
         n_errors++;
         $display("FAIL modes_cnt: got mode2 c=%0d e=%b mode0 c=%0d e=%b want 2,1,0,0",
            o_cnt[1], o_err[1], o_cnt[2], o_err[2]);
      end
   endtask

   task automatic test_backpressure();
      int e_idx;
      bit e_hit, e_multi, e_viol;
      out_ready = 1'b0;
      send(4'($urandom_range(0, 15)));
      e_idx = m_idx; e_hit = m_hit; e_multi = m_multi; e_viol = m_viol[0];
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         cond = 4'($urandom_range(0, 15));
         #1;
         n_checks++;
         if (o_ready[0] !== 0 || o_valid[0] !== 1 || o_idx[0] !== 2'(e_idx) ||
             o_hit[0] !== e_hit || o_multi[0] !== e_multi || o_viol[0] !== e_viol) begin
            n_errors++;
            $display("FAIL hold cyc%0d: got r=%b v=%b i=%0d h=%b m=%b x=%b want r=0 v=1 i=%0d h=%b m=%b x=%b",
               c, o_ready[0], o_valid[0], o_idx[0], o_hit[0], o_multi[0], o_viol[0],
               e_idx, e_hit, e_multi, e_viol);
         end
         tick();
      end
      in_valid = 1'b1;
      cond = 4'b1000;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (o_ready[0] !== 1) begin
         n_errors++;
         $display("FAIL release_ready: got %b want 1", o_ready[0]);
      end
      tick();
      n_checks++;
      if (o_valid[0] !== 1 || o_idx[0] !== 3 || o_hit[0] !== 1) begin
         n_errors++;
         $display("FAIL release_next: got v=%b i=%0d h=%b want v=1 i=3 h=1", o_valid[0], o_idx[0], o_hit[0]);
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (o_valid[0] !== 0) begin
         n_errors++;
         $display("FAIL drain: got out_valid=%b want 0", o_valid[0]);
      end
   endtask

   task automatic test_saturate();
      int exp_seq [5];
      exp_seq = '{1, 2, 3, 3, 3};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         in_valid = 1'b1;
         cond = 4'b1111;
         tick();
         n_checks++;
         if (o_cnt[3] !== 8'(exp_seq[j])) begin
            n_errors++;
            $display("FAIL sat_cnt step%0d: got %0d want %0d", j, o_cnt[3], exp_seq[j]);
         end
      end
      in_valid = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      n_checks++;
      if (o_cnt[3] !== 0 || o_err[3] !== 0 || o_cnt[0] !== 0 || o_err[0] !== 0) begin
         n_errors++;
         $display("FAIL clr_alone: got c3=%0d e3=%b c0=%0d e0=%b want all 0", o_cnt[3], o_err[3], o_cnt[0], o_err[0]);
      end
      clr_err = 1'b1;
      send(4'b1111);
      clr_err = 1'b0;
      n_checks++;
      if (o_cnt[3] !== 1 || o_err[3] !== 1) begin
         n_errors++;
         $display("FAIL clr_with_viol: got c=%0d e=%b want c=1 e=1", o_cnt[3], o_err[3]);
      end
   endtask

   task automatic test_reset_mid();
      send(4'b1111);
      send(4'b0110);
      out_ready = 1'b0;
      #1;
      n_checks++;
      if (o_valid[3] !== 1 || o_cnt[3] !== 3) begin
         n_errors++;
         $display("FAIL premid: got v=%b c=%0d want v=1 c=3", o_valid[3], o_cnt[3]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (o_valid[k] !== 0 || o_idx[k] !== 0 || o_hit[k] !== 0 || o_multi[k] !== 0 ||
             o_viol[k] !== 0 || o_cnt[k] !== 0 || o_err[k] !== 0 || o_ready[k] !== 1) begin
            n_errors++;
            $display("FAIL reset_mid inst%0d: got v=%b i=%0d h=%b m=%b x=%b c=%0d e=%b r=%b want all 0, in_ready=1",
               k, o_valid[k], o_idx[k], o_hit[k], o_multi[k], o_viol[k], o_cnt[k], o_err[k], o_ready[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_err   = ($urandom_range(0, 15) == 0);
         cond      = 4'($urandom_range(0, 15));
         #1;
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (o_ready[k] !== (!m_valid || out_ready)) begin
               n_errors++;
               $display("FAIL rand_ready cyc%0d inst%0d: got %b want %b", c, k, o_ready[k], (!m_valid || out_ready));
            end
         end
         tick();
         for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (o_valid[k] !== m_valid || o_idx[k] !== 2'(m_idx) || o_hit[k] !== m_hit ||
                o_multi[k] !== m_multi || o_viol[k] !== m_viol[k] ||
                o_cnt[k] !== 8'(m_cnt[k]) || o_err[k] !== m_err[k]) begin
               n_errors++;
               $display("FAIL rand_out cyc%0d inst%0d: got v=%b i=%0d h=%b m=%b x=%b c=%0d e=%b want v=%b i=%0d h=%b m=%b x=%b c=%0d e=%b",
                  c, k, o_valid[k], o_idx[k], o_hit[k], o_multi[k], o_viol[k], o_cnt[k], o_err[k],
                  m_valid, m_idx, m_hit, m_multi, m_viol[k], m_cnt[k], m_err[k]);
            end
         end
      end
      in_valid = 1'b0;
      clr_err = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_else();
      test_resolve();
      test_modes();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
